// File: rtl/peripheral_uart_sync_pkg.sv
// -----------------------------------------------------------------------------
// peripheral_uart_sync_pkg
// Shared constants and helpers for the UART input synchroniser / glitch filter.
//
// Contents:
//   SYNC_STAGES_DEF      default synchroniser depth
//   SYNC_FILTER_LEN_DEF  default number of consecutive differing samples needed
//                        to accept a new level
//   sync_cnt_width(len)  width of the per-channel filter counter,
//                        max(1, $clog2(len))
//
// Optional feature macro used by the filter: PERIPHERAL_UART_SYNC_GLITCH_FILTER_EN
// -----------------------------------------------------------------------------
package peripheral_uart_sync_pkg;

   localparam int SYNC_STAGES_DEF     = 2;
   localparam int SYNC_FILTER_LEN_DEF = 4;

   // A one-sample filter still needs a 1-bit counter so that the compare
   // against FILTER_LEN-1 (== 0) stays well formed.
   function automatic int sync_cnt_width(input int len);
      int w;
      w = $clog2(len);
      return (w < 1) ? 1 : w;
   endfunction

endpackage : peripheral_uart_sync_pkg

// File: rtl/peripheral_uart_glitch_filter_wb.sv
// -----------------------------------------------------------------------------
// peripheral_uart_glitch_filter_wb
// Single-channel glitch filter with registered edge detection. It takes one
// already-synchronised bit and produces a debounced level plus one-cycle rise
// and fall pulses that line up with the cycle the new level first appears.
//
// Build option:
//   PERIPHERAL_UART_SYNC_GLITCH_FILTER_EN defined   -> a new level is accepted
//      only after FILTER_LEN consecutive enabled samples that differ from the
//      current filtered level.
//   PERIPHERAL_UART_SYNC_GLITCH_FILTER_EN undefined -> no counter; the filtered
//      level simply loads the input on every enabled sample.
//
// Parameters:
//   FILTER_LEN   consecutive differing samples needed (>= 1)
//   INIT_VALUE   reset level of the filtered output
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   stage_rst_i  synchronous clear (no edge pulse is produced by the clear)
//   sample_en_i  sample strobe; state holds when low
//   sync_i       synchronised input level
//   filt_o       filtered level
//   rise_o       one-cycle pulse on a 0->1 change of filt_o
//   fall_o       one-cycle pulse on a 1->0 change of filt_o
// -----------------------------------------------------------------------------
module peripheral_uart_glitch_filter_wb
   import peripheral_uart_sync_pkg::*;
#(
   parameter int   FILTER_LEN = SYNC_FILTER_LEN_DEF,
   parameter logic INIT_VALUE = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic stage_rst_i,
   input  logic sample_en_i,
   input  logic sync_i,
   output logic filt_o,
   output logic rise_o,
   output logic fall_o
);

   logic filt_r;
   logic filt_next_s;
   logic rise_r;
   logic fall_r;

   if (FILTER_LEN < 1) begin : g_len_chk
      $error("peripheral_uart_glitch_filter_wb: FILTER_LEN must be >= 1");
   end

`ifdef PERIPHERAL_UART_SYNC_GLITCH_FILTER_EN

   localparam int               CNT_W    = sync_cnt_width(FILTER_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_next_s;

   // Next counter / level: a matching sample restarts the run, the last
   // differing sample of a full run accepts the new level.
   always_comb begin
      cnt_next_s  = cnt_r;
      filt_next_s = filt_r;
      if (sample_en_i) begin
         if (sync_i == filt_r) begin
            cnt_next_s = '0;
         end else if (cnt_r == CNT_LAST) begin
            filt_next_s = sync_i;
            cnt_next_s  = '0;
         end else begin
            cnt_next_s = cnt_r + 1'b1;
         end
      end else begin
         cnt_next_s  = cnt_r;
         filt_next_s = filt_r;
      end
   end

   // Run-length counter register; a clear discards any pending transition.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_r <= '0;
      end else if (stage_rst_i) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_next_s;
      end
   end

`else

   // Without the filter the level tracks the input on every enabled sample.
   always_comb begin
      filt_next_s = filt_r;
      if (sample_en_i) begin
         filt_next_s = sync_i;
      end else begin
         filt_next_s = filt_r;
      end
   end

`endif

   // Level and edge registers. Pulses are derived from the same next-state
   // value that loads filt_r, so they appear in the cycle the new level does.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         filt_r <= INIT_VALUE;
         rise_r <= 1'b0;
         fall_r <= 1'b0;
      end else if (stage_rst_i) begin
         filt_r <= INIT_VALUE;
         rise_r <= 1'b0;
         fall_r <= 1'b0;
      end else begin
         filt_r <= filt_next_s;
         rise_r <= ~filt_r &  filt_next_s;
         fall_r <=  filt_r & ~filt_next_s;
      end
   end

   assign filt_o = filt_r;
   assign rise_o = rise_r;
   assign fall_o = fall_r;

endmodule : peripheral_uart_glitch_filter_wb

// File: rtl/peripheral_uart_sync_filter_wb.sv
// -----------------------------------------------------------------------------
// peripheral_uart_sync_filter_wb
// Multi-channel clock-domain synchroniser followed by a per-channel glitch
// filter and edge detector. Intended for UART RX and modem-status inputs
// (CTS, DSR, DCD, RI): it delivers clean levels to the receiver sampler and
// single-cycle change pulses to the modem-status logic.
//
// Build option: PERIPHERAL_UART_SYNC_GLITCH_FILTER_EN enables the counting
// glitch filter; when undefined the filtered level loads the synchroniser
// output on every sample strobe (see peripheral_uart_glitch_filter_wb).
//
// Parameters:
//   WIDTH        number of independent channels
//   STAGES       synchroniser depth (>= 2)
//   FILTER_LEN   consecutive differing samples needed to accept a level (>= 1)
//   INIT_VALUE   reset level of every register (UART idle-high)
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   stage_rst_i  synchronous clear of all state
//   sample_en_i  filter sample strobe (e.g. baud x16 tick)
//   async_dat_i  asynchronous inputs            [WIDTH]
//   sync_dat_o   last synchroniser stage         [WIDTH]
//   filt_dat_o   filtered level                  [WIDTH]
//   rise_o       one-cycle 0->1 pulse of filt    [WIDTH]
//   fall_o       one-cycle 1->0 pulse of filt    [WIDTH]
// -----------------------------------------------------------------------------
module peripheral_uart_sync_filter_wb
   import peripheral_uart_sync_pkg::*;
#(
   parameter int   WIDTH      = 1,
   parameter int   STAGES     = SYNC_STAGES_DEF,
   parameter int   FILTER_LEN = SYNC_FILTER_LEN_DEF,
   parameter logic INIT_VALUE = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             stage_rst_i,
   input  logic             sample_en_i,
   input  logic [WIDTH-1:0] async_dat_i,
   output logic [WIDTH-1:0] sync_dat_o,
   output logic [WIDTH-1:0] filt_dat_o,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o
);

   if (STAGES < 2) begin : g_stages_chk
      $error("peripheral_uart_sync_filter_wb: STAGES must be >= 2");
   end

   // Stage 0 captures the asynchronous input; stage STAGES-1 is the output.
   logic [STAGES-1:0][WIDTH-1:0] sync_r;

   // Synchroniser chain: clocked every cycle, independent of sample_en_i.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_r <= {STAGES{{WIDTH{INIT_VALUE}}}};
      end else if (stage_rst_i) begin
         sync_r <= {STAGES{{WIDTH{INIT_VALUE}}}};
      end else begin
         sync_r <= {sync_r[STAGES-2:0], async_dat_i};
      end
   end

   assign sync_dat_o = sync_r[STAGES-1];

   for (genvar c = 0; c < WIDTH; c++) begin : g_chan
      peripheral_uart_glitch_filter_wb #(
         .FILTER_LEN (FILTER_LEN),
         .INIT_VALUE (INIT_VALUE)
      ) u_filt (
         .clk_i       (clk_i),
         .rst_i       (rst_i),
         .stage_rst_i (stage_rst_i),
         .sample_en_i (sample_en_i),
         .sync_i      (sync_r[STAGES-1][c]),
         .filt_o      (filt_dat_o[c]),
         .rise_o      (rise_o[c]),
         .fall_o      (fall_o[c])
      );
   end

endmodule : peripheral_uart_sync_filter_wb

// File: tb/tb_peripheral_uart_sync_filter_wb.sv
// -----------------------------------------------------------------------------
// tb_peripheral_uart_sync_filter_wb
// Scoreboard bench: the stimulus process drives inputs on the falling edge and
// pushes the reference model's expected outputs for the coming rising edge;
// a monitor pops one entry after every rising edge and compares.
// Without PERIPHERAL_UART_SYNC_GLITCH_FILTER_EN the filter degenerates to a
// one-sample acceptance, so the model uses an effective length of 1.
// -----------------------------------------------------------------------------
module tb_peripheral_uart_sync_filter_wb;

   localparam int   WIDTH      = 4;
   localparam int   STAGES     = 2;
   localparam int   FILTER_LEN = 4;
   localparam logic INIT_VALUE = 1'b1;
`ifdef PERIPHERAL_UART_SYNC_GLITCH_FILTER_EN
   localparam int   EFF_LEN    = FILTER_LEN;
`else
   localparam int   EFF_LEN    = 1;
`endif
   localparam logic [WIDTH-1:0] IDLE = {WIDTH{INIT_VALUE}};

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             stage_rst_i;
   logic             sample_en_i;
   logic [WIDTH-1:0] async_dat_i;
   logic [WIDTH-1:0] sync_dat_o;
   logic [WIDTH-1:0] filt_dat_o;
   logic [WIDTH-1:0] rise_o;
   logic [WIDTH-1:0] fall_o;

   always #5 clk_i = ~clk_i;

   peripheral_uart_sync_filter_wb #(
      .WIDTH      (WIDTH),
      .STAGES     (STAGES),
      .FILTER_LEN (FILTER_LEN),
      .INIT_VALUE (INIT_VALUE)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .stage_rst_i (stage_rst_i),
      .sample_en_i (sample_en_i),
      .async_dat_i (async_dat_i),
      .sync_dat_o  (sync_dat_o),
      .filt_dat_o  (filt_dat_o),
      .rise_o      (rise_o),
      .fall_o      (fall_o)
   );

   typedef struct packed {
      logic [WIDTH-1:0] sync;
      logic [WIDTH-1:0] filt;
      logic [WIDTH-1:0] rise;
      logic [WIDTH-1:0] fall;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   passed = 0;
   int   cycle  = 0;

   // ---------------- reference model ----------------
   // Input history: the synchroniser output is the input driven STAGES edges ago.
   logic [WIDTH-1:0] m_hist[$];
   logic [WIDTH-1:0] m_sync;
   logic [WIDTH-1:0] m_filt;
   int               m_run[WIDTH];   // consecutive enabled samples differing from m_filt

   task automatic model_clear();
      m_hist.delete();
      for (int i = 0; i < STAGES - 1; i++) m_hist.push_back(IDLE);
      m_sync = IDLE;
      m_filt = IDLE;
      for (int c = 0; c < WIDTH; c++) m_run[c] = 0;
   endtask

   task automatic model_edge(input logic [WIDTH-1:0] a, input logic en,
                             input logic srst, input logic rst);
      exp_t e;
      e.rise = '0;
      e.fall = '0;
      if (rst || srst) begin
         model_clear();
      end else begin
         if (en) begin
            for (int c = 0; c < WIDTH; c++) begin
               if (m_sync[c] == m_filt[c]) begin
                  m_run[c] = 0;
               end else begin
                  m_run[c] = m_run[c] + 1;
                  if (m_run[c] == EFF_LEN) begin
                     m_filt[c] = m_sync[c];
                     m_run[c]  = 0;
                     if (m_filt[c]) e.rise[c] = 1'b1;
                     else           e.fall[c] = 1'b1;
                  end
               end
            end
         end
         m_hist.push_back(a);
         m_sync = m_hist.pop_front();
      end
      e.sync = m_sync;
      e.filt = m_filt;
      exp_q.push_back(e);
   endtask

   // ---------------- stimulus ----------------
   task automatic step(input logic [WIDTH-1:0] a, input logic en,
                       input logic srst, input logic rst);
      @(negedge clk_i);
      async_dat_i = a;
      sample_en_i = en;
      stage_rst_i = srst;
      rst_i       = rst;
      model_edge(a, en, srst, rst);
   endtask

   task automatic steps(input int n, input logic [WIDTH-1:0] a, input logic en);
      for (int i = 0; i < n; i++) step(a, en, 1'b0, 1'b0);
   endtask

   // ---------------- monitor ----------------
   task automatic check(input string name, input logic [WIDTH-1:0] act,
                        input logic [WIDTH-1:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s cycle %0d: got %b expected %b", name, cycle, act, exp);
   endtask

   exp_t mon_e;

   // Compare one expected entry per clock, away from the active edge.
   always @(posedge clk_i) begin
      #1;
      cycle++;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("sync_dat_o", sync_dat_o, mon_e.sync);
         check("filt_dat_o", filt_dat_o, mon_e.filt);
         check("rise_o",     rise_o,     mon_e.rise);
         check("fall_o",     fall_o,     mon_e.fall);
      end
   end

   initial begin
      logic [WIDTH-1:0] cur;
      logic             en;
      rst_i       = 1'b1;
      stage_rst_i = 1'b0;
      sample_en_i = 1'b0;
      async_dat_i = IDLE;
      model_clear();

      // Reset held across several edges, then released.
      for (int i = 0; i < 3; i++) step(IDLE, 1'b0, 1'b0, 1'b1);
      steps(2, IDLE, 1'b1);

      // Idle-high to low on every channel, then back.
      steps(10, 4'h0, 1'b1);
      steps(10, 4'hF, 1'b1);

      // Three-cycle low glitch.
      steps(3, 4'h0, 1'b1);
      steps(12, 4'hF, 1'b1);

      // Gated sampling: one strobe every 16 cycles, input goes low.
      for (int i = 0; i < 16 * 7; i++) step(4'h0, (i % 16) == 15, 1'b0, 1'b0);

      // Clear while filtered low: level returns to idle without a pulse.
      step(4'h0, 1'b0, 1'b1, 1'b0);
      // Pending 1->0 transition discarded by a mid-run clear.
      steps(4, 4'h0, 1'b1);
      step(4'h0, 1'b1, 1'b1, 1'b0);
      steps(10, 4'h0, 1'b1);

      // Channels 0 and 3 toggle together, then return.
      steps(10, 4'b1001, 1'b1);
      steps(10, 4'b0000, 1'b1);
      steps(10, 4'b0110, 1'b1);

      // Randomised traffic with occasional clears and resets.
      cur = IDLE;
      for (int i = 0; i < 3000; i++) begin
         for (int c = 0; c < WIDTH; c++)
            if ($urandom_range(0, (i / 500) % 2 == 0 ? 3 : 12) == 0) cur[c] = ~cur[c];
         en = ((i / 250) % 2 == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
         step(cur, en, $urandom_range(0, 299) == 0, $urandom_range(0, 999) == 0);
      end
      steps(20, cur, 1'b1);

      // Let the monitor drain every outstanding expectation, bounded.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk_i);
      #2;
      checks++;
      if (exp_q.size() == 0) passed++;
      else $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule : tb_peripheral_uart_sync_filter_wb
